// File: rtl/isr_arbiter.sv
// isr_arbiter: shares one integer-square-root unit among N_REQ requesters, one operation at a time.
// Define ISR_ARB_ROUND_ROBIN_EN for round-robin grant; when undefined, fixed priority (lowest index wins).
module isr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*64-1:0] req_value,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    resp_valid,
    output logic [31:0]         resp_result,
    input  logic [N_REQ-1:0]    resp_ready,
    output logic                busy,
    output logic                isr_start,
    output logic [63:0]         isr_value,
    input  logic [31:0]         isr_result,
    input  logic                isr_done
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic [63:0]      grant_value;
    logic             seen_low;
    logic             owner_ready;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

`ifdef ISR_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr;

    function automatic logic [IDX_W-1:0] rr_slot(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    // Search upward from the pointer with wrap-around; first pending requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_any && req_valid[rr_slot(ptr, k)]) begin
                grant_any = 1'b1;
                grant_idx = rr_slot(ptr, k);
            end
        end
    end
`else
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_any && req_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end
`endif

    always_comb begin
        grant_value = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx == IDX_W'(k)) grant_value = req_value[64*k +: 64];
        end
    end

    // The accept pulse is combinational so the request is taken on the same edge it is granted.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && !reset && grant_any) req_ready[grant_idx] = 1'b1;
    end

    assign owner_ready = resp_ready[owner];

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            owner       <= '0;
            seen_low    <= 1'b0;
            busy        <= 1'b0;
            isr_start   <= 1'b0;
            isr_value   <= '0;
            resp_valid  <= '0;
            resp_result <= '0;
`ifdef ISR_ARB_ROUND_ROBIN_EN
            ptr         <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        owner     <= grant_idx;
                        isr_value <= grant_value;
                        isr_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    isr_start <= 1'b0;
                    seen_low  <= 1'b0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // A done level left over from the previous operation is ignored until done has dropped once.
                    if (isr_done && seen_low) begin
                        resp_result <= isr_result;
                        resp_valid  <= onehot(owner);
                        isr_value   <= '0;
                        state       <= S_RESP;
                    end else if (!isr_done) begin
                        seen_low <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (owner_ready) begin
                        resp_valid <= '0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
`ifdef ISR_ARB_ROUND_ROBIN_EN
                        ptr        <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_isr_arbiter.sv
// Self-checking bench for isr_arbiter: behavioural ISR with stale done levels, cycle model, directed and random traffic.
module tb_isr_arbiter;
    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [255:0] req_value;
    logic [3:0]   req_ready;
    logic [3:0]   resp_valid;
    logic [31:0]  resp_result;
    logic [3:0]   resp_ready;
    logic         busy;
    logic         isr_start;
    logic [63:0]  isr_value;
    logic [31:0]  isr_result;
    logic         isr_done;

    int checks = 0;
    int failures = 0;

    isr_arbiter #(.N_REQ(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_value(req_value), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_result(resp_result), .resp_ready(resp_ready),
        .busy(busy), .isr_start(isr_start), .isr_value(isr_value),
        .isr_result(isr_result), .isr_done(isr_done)
    );

    initial forever #5 clock = ~clock;

    function automatic logic [31:0] isqrt(input logic [63:0] v);
        logic [31:0] r;
        logic [31:0] t;
        r = 32'd0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if (64'(t) * 64'(t) <= v) r = t;
        end
        return r;
    endfunction

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural ISR: done may linger high for a few cycles after start, then drops, then rises with the result.
    bit          isr_pend = 0;
    bit          isr_dropped = 0;
    int          stale_left = 0;
    int          lat_left = 0;
    logic [63:0] isr_op = '0;
    initial begin
        isr_done = 1'b0;
        isr_result = '0;
    end
    always @(posedge clock) begin
        if (reset) begin
            isr_done   <= 1'b0;
            isr_result <= '0;
            isr_pend = 0;
        end else if (isr_start) begin
            isr_pend    = 1;
            isr_dropped = 0;
            isr_op      = isr_value;
            stale_left  = $urandom_range(0, 2);
            lat_left    = $urandom_range(1, 6);
        end else if (isr_pend) begin
            if (stale_left > 0) stale_left--;
            else if (!isr_dropped) begin
                isr_done <= 1'b0;
                isr_dropped = 1;
            end else if (lat_left > 1) lat_left--;
            else begin
                isr_done   <= 1'b1;
                isr_result <= isqrt(isr_op);
                isr_pend = 0;
            end
        end
    end

    // Reference model: one job at a time, tracked by owner, operand, cycles since accept and response phase.
    bit          m_busy = 0;
    bit          m_resp = 0;
    bit          m_seen = 0;
    int          m_age = 0;
    int          m_owner = 0;
    int          m_ptr = 0;
    logic [63:0] m_val = '0;
    int          exp_w;
    logic [3:0]  exp_ready;
    int          grant_log[$];
    logic [31:0] result_log[$];

    always @(negedge clock) begin
        check("req_ready_onehot", 64'($onehot0(req_ready)), 64'd1);
        check("resp_valid_onehot", 64'($onehot0(resp_valid)), 64'd1);
        exp_w = (!reset && !m_busy) ? pick(req_valid, m_ptr) : -1;
        exp_ready = (exp_w >= 0) ? (4'b0001 << exp_w) : 4'b0000;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("busy", 64'(busy), 64'(m_busy));
        check("isr_start", 64'(isr_start), 64'(m_busy && m_age == 1));
        check("isr_value", isr_value, (m_busy && !m_resp) ? m_val : 64'd0);
        check("resp_valid", 64'(resp_valid), m_resp ? 64'(4'b0001 << m_owner) : 64'd0);
        if (m_resp) check("resp_result", 64'(resp_result), 64'(isqrt(m_val)));
        for (int i = 0; i < 4; i++) begin
            if (!reset && req_valid[i] && req_ready[i]) grant_log.push_back(i);
            if (!reset && resp_valid[i] && resp_ready[i]) result_log.push_back(resp_result);
        end
        if (reset) begin
            m_busy = 0; m_resp = 0; m_seen = 0; m_age = 0; m_ptr = 0;
        end else if (!m_busy) begin
            if (exp_w >= 0) begin
                m_busy = 1; m_resp = 0; m_age = 1; m_owner = exp_w;
                m_val = req_value[64*exp_w +: 64];
            end
        end else if (m_age == 1) begin
            m_seen = 0; m_age = 2;
        end else if (!m_resp) begin
            if (isr_done && m_seen) m_resp = 1;
            else if (!isr_done) m_seen = 1;
        end else if (resp_ready[m_owner]) begin
            m_busy = 0; m_resp = 0;
`ifdef ISR_ARB_ROUND_ROBIN_EN
            m_ptr = (m_owner + 1) % 4;
`endif
        end
    end

    task automatic serve(input int idx, input logic [63:0] val, input int hold, input bit pre,
                         output logic [31:0] got);
        int n;
        if (!pre) begin
            @(posedge clock); #1;
            req_value[64*idx +: 64] = val;
            req_valid[idx] = 1'b1;
            @(negedge clock);
        end
        n = 0;
        while (!req_ready[idx] && n < 100) begin @(negedge clock); n++; end
        check("accept_wait", 64'(req_ready[idx]), 64'd1);
        @(posedge clock); #1 req_valid[idx] = 1'b0;
        @(negedge clock); check("start_after_accept", 64'(isr_start), 64'd1);
        @(negedge clock); check("start_single_pulse", 64'(isr_start), 64'd0);
        n = 0;
        while (!resp_valid[idx] && n < 100) begin @(negedge clock); n++; end
        check("resp_wait", 64'(resp_valid[idx]), 64'd1);
        got = resp_result;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check("hold_valid", 64'(resp_valid[idx]), 64'd1);
            check("hold_result", 64'(resp_result), 64'(got));
            check("hold_no_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clock); #1 resp_ready[idx] = 1'b1;
        @(posedge clock); #1 resp_ready[idx] = 1'b0;
        @(negedge clock);
        check("done_busy", 64'(busy), 64'd0);
        check("done_resp_valid", 64'(resp_valid), 64'd0);
    endtask

    function automatic logic [63:0] rand_operand();
        logic [31:0] r;
        case ($urandom_range(0, 2))
            0: return {$urandom, $urandom};
            1: return 64'($urandom_range(0, 100000));
            default: begin
                r = $urandom;
                return 64'(r) * 64'(r);
            end
        endcase
    endfunction

    initial begin
        logic [31:0] got;
        logic [3:0]  acc;
        int          n;
        reset = 1'b1;
        req_valid = '0;
        req_value = '0;
        resp_ready = '0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_isr_start", 64'(isr_start), 64'd0);
        check("rst_isr_value", isr_value, 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_result", 64'(resp_result), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);

        serve(0, 64'd25, 0, 0, got);
        check("single_result", 64'(got), 64'd5);
        serve(1, 64'hFFFF_FFFF_FFFF_FFE8, 0, 0, got);
        check("wrap_result", 64'(got), 64'hFFFF_FFFF);

        // Backpressure with a competing request pending behind the owner.
        @(posedge clock); #1;
        req_value[64*2 +: 64] = 64'd100; req_valid[2] = 1'b1;
        req_value[64*3 +: 64] = 64'd49;  req_valid[3] = 1'b1;
        @(negedge clock);
        serve(2, 64'd100, 5, 1, got);
        check("bp_result", 64'(got), 64'd10);
        serve(3, 64'd49, 0, 1, got);
        check("pending_result", 64'(got), 64'd7);

        // Reset during WAIT after leaving a nonzero pointer behind.
        serve(2, 64'd16, 0, 0, got);
        check("pre_reset_result", 64'(got), 64'd4);
        @(posedge clock); #1;
        req_value[64*1 +: 64] = 64'd36; req_valid[1] = 1'b1;
        n = 0;
        @(negedge clock);
        while (!req_ready[1] && n < 100) begin @(negedge clock); n++; end
        check("rw_accept", 64'(req_ready[1]), 64'd1);
        @(posedge clock); #1 req_valid[1] = 1'b0;
        @(negedge clock); check("rw_start", 64'(isr_start), 64'd1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("rw_busy", 64'(busy), 64'd0);
        check("rw_isr_start", 64'(isr_start), 64'd0);
        check("rw_isr_value", isr_value, 64'd0);
        check("rw_resp_valid", 64'(resp_valid), 64'd0);
        check("rw_resp_result", 64'(resp_result), 64'd0);
        @(posedge clock); #1;
        req_value[64*1 +: 64] = 64'd81;  req_valid[1] = 1'b1;
        req_value[64*3 +: 64] = 64'd121; req_valid[3] = 1'b1;
        @(negedge clock);
        serve(1, 64'd81, 0, 1, got);
        check("after_reset_result", 64'(got), 64'd9);
        serve(3, 64'd121, 0, 1, got);
        check("after_reset_second", 64'(got), 64'd11);

        // Contention: all four requesters at once.
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        grant_log.delete();
        result_log.delete();
        req_value = {64'd9, 64'd4, 64'd1, 64'd0};
        req_valid = 4'hF;
        resp_ready = 4'hF;
        n = 0;
        while (result_log.size() < 4 && n < 300) begin
            @(negedge clock);
            acc = req_valid & req_ready;
            @(posedge clock); #1;
`ifdef ISR_ARB_ROUND_ROBIN_EN
            req_valid = req_valid & ~acc;
`else
            req_valid = req_valid & ~(acc & 4'b1110);
`endif
            n++;
        end
        req_valid = '0;
        resp_ready = '0;
        check("contention_results", 64'(result_log.size()), 64'd4);
        check("contention_grants", 64'(grant_log.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < grant_log.size() && k < result_log.size()) begin
`ifdef ISR_ARB_ROUND_ROBIN_EN
                check("grant_order", 64'(grant_log[k]), 64'(k));
                check("grant_result", 64'(result_log[k]), 64'(k));
`else
                check("grant_order", 64'(grant_log[k]), 64'd0);
                check("grant_result", 64'(result_log[k]), 64'd0);
`endif
            end
        end

        // Randomized traffic, backpressure and occasional resets, checked by the model every cycle.
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            acc = req_valid & req_ready;
            @(posedge clock); #1;
            reset = ($urandom_range(0, 499) == 0);
            resp_ready = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_value[64*i +: 64] = rand_operand();
                    req_valid[i] = 1'b1;
                end
            end
        end
        reset = 1'b0;
        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/isr_arbiter.md
# isr_arbiter

Round-robin scheduler that shares one integer-square-root unit (ISR: 64-bit `value` in, 32-bit floor-sqrt `result` out, `start`/`done` handshake) among `N_REQ` requesters. It accepts one request at a time and launches the ISR with a one-cycle start pulse. It waits for a qualified done and returns the result to the originating requester over a valid/ready response channel. It sits between client blocks and the single ISR instance; the ISR's `clock` and `reset` come from the same sources as the arbiter's.

## Interface
- `N_REQ`, 4: number of requesters; valid range 2–8.
- `IDX_W`, `$clog2(N_REQ)`: requester index width; derived, not overridden.
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in `N_REQ`: per-requester request pending.
- `req_value` in `N_REQ*64`: packed operands; requester i at bits `[64*i+63:64*i]`.
- `req_ready` out `N_REQ`: one-hot accept pulse; request i is taken on the edge where `req_valid[i] & req_ready[i]`.
- `resp_valid` out `N_REQ`: one-hot result-available flag for the owning requester.
- `resp_result` out 32: result, shared by all requesters, qualified by `resp_valid`.
- `resp_ready` in `N_REQ`: per-requester result accept.
- `busy` out 1: high in every state except IDLE.
- `isr_start` out 1: ISR start pulse.
- `isr_value` out 64: ISR operand.
- `isr_result` in 32: ISR result.
- `isr_done` in 1: ISR done level.

## Operation
- State machine has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If any `req_valid` is high, select a winner `w`, drive `req_ready[w]=1` combinationally in that cycle, and latch `req_value[w]` and `w`.
  - Next state is ISSUE. With no request, stay in IDLE.
- ISSUE
  - `isr_start=1` for exactly one cycle. Next state is WAIT.
- WAIT
  - `isr_done` may still be high from the previous operation. It is ignored until it has been sampled low at least once since ISSUE (`seen_low` flag, cleared in ISSUE).
  - On the first edge with `isr_done & seen_low`, latch `isr_result`. Next state is RESP.
- RESP
  - Hold `resp_valid[w]=1` and `resp_result`. On `resp_ready[w]`, go to IDLE and set the round-robin pointer to `w+1` (mod `N_REQ`).
  - `resp_ready` of non-owners is ignored.
- `isr_value` holds the latched operand from ISSUE through WAIT, and is 0 otherwise.
- Round-robin selection searches from the pointer upward with wrap-around; the first asserted `req_valid` wins.
- Requests raised while `busy` are not accepted and stay pending; `req_valid` must hold until accepted.
- Only one operation is in flight; there is no queueing.

## Timing
- Reset values:
  - all outputs 0 (`req_ready`, `resp_valid`, `resp_result`, `busy`, `isr_start`, `isr_value`);
  - state IDLE, pointer 0, `seen_low` 0.
- Reset mid-operation (any state): the operation is abandoned with no response; the ISR is reset by the same signal.
- Accept edge T; `isr_start` is high in cycle T+1; WAIT starts at T+2.
- If the ISR raises a qualified done at edge D, `resp_valid` is high from cycle D+1.
- A response accepted at edge R allows the next accept at the earliest in cycle R+1 (IDLE).
- Minimum turnaround between consecutive accepts is ISR latency + 3 cycles.
- `req_valid` and `resp_ready` from the same requester in the same cycle: the response completes first; the new request is considered in the following IDLE cycle.

## Configuration
- `ISR_ARB_ROUND_ROBIN_EN` defined: round-robin selection as above.
- Not defined:
  - fixed priority, lowest index wins;
  - no pointer register; `resp_ready` handling is otherwise identical.

## Test plan
- Single request: hold `reset=1` for 4 cycles, then requester 0 sends value 25. Required:
  - `isr_start` pulses once, 1 cycle after accept;
  - `resp_valid[0]=1` with `resp_result=5`.
- Wrap operand: requester 1 sends value 64'hFFFF_FFFF_FFFF_FFE8 (-24). Required: `resp_result=32'hFFFF_FFFF`; the stale-done guard prevents early completion.
- Contention: all 4 requesters assert at once with values 0, 1, 4, 9.
  - With the macro: grant order 0, 1, 2, 3; results 0, 1, 2, 3.
  - Without the macro: requester 0 re-asserting continuously starves requesters 1–3.
- Backpressure: hold `resp_ready[w]=0` for 5 cycles. Required: `resp_valid` and `resp_result` stay stable and no `req_ready` pulses; completion follows one cycle after `resp_ready` rises.
- Reset in WAIT: assert `reset` for 1 cycle. Required: all outputs 0 on the next cycle, no `resp_valid`, and the next request is served normally with pointer 0.
- Protocol check on every cycle: `req_ready` and `resp_valid` are at most one-hot, and `isr_start` is never high outside ISSUE.
